img_capture_ctrl: RTL
=====================

IMG_CAPTURE_CTRL -- requirements
Module: img_capture_ctrl

Interface
REQ-001 SHALL have parameter ImgWidth, default 256, expected pixels per line.
REQ-002 SHALL have parameter ImgHeight, default 256, expected lines per frame.
REQ-003 SHALL have parameter SensorRstCycles, default 16, cycles img_rst_ is held low.
REQ-004 SHALL have parameter HighlightThresh, default 12'hF00; pixels >= this count as highlight.
REQ-005 SHALL have parameter ShadowThresh, default 12'h0FF; pixels <= this count as shadow.
REQ-006 SHALL have ports as follows.
- clk  in  1  pixel clock; one clock, all logic on its rising edge.
- rst_  in  1  asynchronous, active-low reset.
- cmd_trig  in  1  one-cycle capture request.
- cmd_rst_sensor  in  1  sampled with cmd_trig; 1 = pulse sensor reset before capture.
- cmd_skip  in  4  frames to discard before the captured frame.
- img_rst_  out  1  sensor reset, active-low.
- img_d  in  12  sensor pixel data.
- img_fv  in  1  frame valid.
- img_lv  in  1  line valid.
- px_valid  out  1  output pixel valid.
- px_data  out  12  output pixel.
- px_ready  in  1  downstream accept.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse at end of capture.
- err_ovf  out  1  sticky; pixel dropped by backpressure.
- err_size  out  1  sticky; frame geometry mismatch.
- stat_px  out  32  pixels captured.
- stat_hi  out  32  highlight pixels.
- stat_lo  out  32  shadow pixels.

Function
REQ-007 SHALL register img_fv, img_lv and img_d once; all edge detection SHALL use the registered copies.
REQ-008 SHALL implement states IDLE, SRST, SYNC, ARM, SKIP, CAP.
REQ-009 IDLE: on cmd_trig, SHALL latch cmd_skip, clear err_*, stat_* and line/column counters, and go to SRST if cmd_rst_sensor=1, else SYNC; cmd_trig outside IDLE SHALL be ignored.
REQ-010 SRST: SHALL drive img_rst_=0 for exactly SensorRstCycles cycles, then go to SYNC; img_rst_ SHALL be 1 in all other states.
REQ-011 SYNC: SHALL wait until registered fv=0, so a frame already in progress is never captured, then go to ARM.
REQ-012 ARM: on fv rising edge, SHALL go to CAP if the skip counter is 0, else decrement it and go to SKIP.
REQ-013 SKIP: on fv falling edge, SHALL return to ARM.
REQ-014 CAP: each cycle with registered fv=1 and lv=1 SHALL present the pixel on px_valid/px_data one cycle after that register stage, i.e. two clk after the sensor drove it.
REQ-015 CAP: if px_valid=1 and px_ready=0 when a new pixel arrives, SHALL drop the new pixel, keep the held one, and set err_ovf; px_valid SHALL clear only on px_ready=1 or reset.
REQ-016 SHALL increment stat_px per accepted-into-register pixel (excluding dropped), stat_hi if pixel>=HighlightThresh, and stat_lo if pixel<=ShadowThresh; both stat_hi and stat_lo MAY increment for one pixel if the thresholds overlap.
REQ-017 SHALL count columns per line; on lv falling edge, if column count != ImgWidth, SHALL set err_size; SHALL count lines.
REQ-018 On fv falling edge in CAP, SHALL set err_size if line count != ImgHeight, pulse done for one cycle, and return to IDLE; stats and errors SHALL hold until the next cmd_trig.
REQ-019 SHALL saturate the column and line counters at their maximum rather than wrap.
REQ-020 busy SHALL be 0 in IDLE and 1 otherwise, including the done cycle's source state.

Reset
REQ-021 On rst_=0, asynchronously: state=IDLE, img_rst_=0, then img_rst_=1 from the first cycle after release; px_valid=0, px_data=0, busy=0, done=0, err_*=0, stat_*=0.
REQ-022 Reset mid-CAP SHALL discard the partial frame with no done pulse.

Structure
REQ-023 The state enum, the 12-bit pixel width constant and the stat width constant SHALL live in the shared package img_pkg.
REQ-024 Threshold compare and the three stat counters SHALL be the sub-module img_px_stats; the FSM, counters and output register SHALL stay in img_capture_ctrl.

Verification
REQ-025 Sensor model 4x2 (ImgWidth=4, ImgHeight=2), data 0xFFF descending, px_ready=1, cmd_skip=0 -> 8 pixels FFF..FF8 in order, stat_px=8, stat_hi=8, done once, err_*=0.
REQ-026 cmd_trig with cmd_rst_sensor=1, SensorRstCycles=16 -> img_rst_ low exactly 16 cycles, then capture proceeds as REQ-025.
REQ-027 cmd_skip=2 -> first two frames produce no px_valid; third frame captured; done after its fv fall.
REQ-028 px_ready=0 for 3 cycles mid-line -> err_ovf=1, stat_px=6, first held pixel delivered intact once px_ready returns.
REQ-029 Model emits 3-pixel line or 3 lines -> err_size=1 at line end / frame end, done still pulses.
REQ-030 cmd_trig asserted mid-frame (fv=1) -> that frame ignored, next frame captured; rst_ low during CAP -> outputs reset, no done.

Source files
------------

// File: rtl/img_pkg.sv
// Shared types and constants for the image capture controller and its stats block.
package img_pkg;

    localparam int PixW  = 12;
    localparam int StatW = 32;
    localparam int CntW  = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SRST = 3'd1,
        ST_SYNC = 3'd2,
        ST_ARM  = 3'd3,
        ST_SKIP = 3'd4,
        ST_CAP  = 3'd5
    } state_t;

    // Geometry counters stick at all-ones so a runaway line cannot wrap back to a legal count.
    function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] v);
        return (&v) ? v : v + CntW'(1);
    endfunction

endpackage

// File: rtl/img_capture_ctrl_if.sv
// Output pixel stream: valid/data from the controller, ready from the consumer.
interface img_capture_ctrl_if;
    import img_pkg::*;

    logic            px_valid;
    logic [PixW-1:0] px_data;
    logic            px_ready;

    modport master (output px_valid, output px_data, input px_ready);
    modport slave  (input px_valid, input px_data, output px_ready);

endinterface

// File: rtl/img_px_stats.sv
// Per-capture pixel statistics: total accepted, highlight and shadow counts.
module img_px_stats
    import img_pkg::*;
#(
    parameter logic [PixW-1:0] HighlightThresh = 12'hF00,
    parameter logic [PixW-1:0] ShadowThresh    = 12'h0FF
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             clr,
    input  logic             en,
    input  logic [PixW-1:0]  pix,
    output logic [StatW-1:0] stat_px,
    output logic [StatW-1:0] stat_hi,
    output logic [StatW-1:0] stat_lo
);

    // Bit order: 0 = every pixel, 1 = highlight, 2 = shadow. Overlapping thresholds may hit both.
    logic [2:0]       hit;
    logic [StatW-1:0] cnt [3];

    assign hit = {pix <= ShadowThresh, pix >= HighlightThresh, 1'b1};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cnt
            logic [StatW-1:0] cnt_reg;

            always_ff @(posedge clk or negedge rst_) begin
                if (!rst_) begin
                    cnt_reg <= '0;
                end else if (clr) begin
                    cnt_reg <= '0;
                end else if (en && hit[gi]) begin
                    cnt_reg <= cnt_reg + StatW'(1);
                end
            end

            assign cnt[gi] = cnt_reg;
        end
    endgenerate

    assign stat_px = cnt[0];
    assign stat_hi = cnt[1];
    assign stat_lo = cnt[2];

endmodule

// File: rtl/img_capture_ctrl.sv
// Single-frame capture controller: optional sensor reset, frame sync and skip,
// pixel forwarding with drop-on-backpressure, geometry checking and statistics.
module img_capture_ctrl
    import img_pkg::*;
#(
    parameter int              ImgWidth        = 256,
    parameter int              ImgHeight       = 256,
    parameter int              SensorRstCycles = 16,
    parameter logic [PixW-1:0] HighlightThresh = 12'hF00,
    parameter logic [PixW-1:0] ShadowThresh    = 12'h0FF
) (
    input  logic                clk,
    input  logic                rst_,
    input  logic                cmd_trig,
    input  logic                cmd_rst_sensor,
    input  logic [3:0]          cmd_skip,
    output logic                img_rst_,
    input  logic [PixW-1:0]     img_d,
    input  logic                img_fv,
    input  logic                img_lv,
    img_capture_ctrl_if.master  px,
    output logic                busy,
    output logic                done,
    output logic                err_ovf,
    output logic                err_size,
    output logic [StatW-1:0]    stat_px,
    output logic [StatW-1:0]    stat_hi,
    output logic [StatW-1:0]    stat_lo
);

    localparam logic [CntW-1:0] ImgW    = CntW'(ImgWidth);
    localparam logic [CntW-1:0] ImgH    = CntW'(ImgHeight);
    localparam logic [CntW-1:0] RstLast = CntW'(SensorRstCycles - 1);

    state_t          state_reg, state_next;
    logic            fv_reg, lv_reg, fv_prev_reg, lv_prev_reg;
    logic [PixW-1:0] d_reg;
    logic [3:0]      skip_reg;
    logic [CntW-1:0] rst_cnt_reg, col_reg, line_reg, line_total;
    logic            err_ovf_reg, err_size_reg, img_rst_reg;
    logic            px_valid_reg;
    logic [PixW-1:0] px_data_reg;

    logic fv_rise, fv_fall, lv_fall;
    logic start, cap_window, line_end;
    logic pix_in, pix_take, pix_drop;

    // Sensor inputs are registered once; every edge decision looks only at these copies.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            fv_reg      <= 1'b0;
            lv_reg      <= 1'b0;
            fv_prev_reg <= 1'b0;
            lv_prev_reg <= 1'b0;
            d_reg       <= '0;
        end else begin
            fv_reg      <= img_fv;
            lv_reg      <= img_lv;
            fv_prev_reg <= fv_reg;
            lv_prev_reg <= lv_reg;
            d_reg       <= img_d;
        end
    end

    assign fv_rise = fv_reg & ~fv_prev_reg;
    assign fv_fall = ~fv_reg & fv_prev_reg;
    assign lv_fall = ~lv_reg & lv_prev_reg;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE: if (cmd_trig) state_next = cmd_rst_sensor ? ST_SRST : ST_SYNC;
            ST_SRST: if (rst_cnt_reg == RstLast) state_next = ST_SYNC;
            ST_SYNC: if (!fv_reg) state_next = ST_ARM;
            ST_ARM:  if (fv_rise) state_next = (skip_reg == 4'd0) ? ST_CAP : ST_SKIP;
            ST_SKIP: if (fv_fall) state_next = ST_ARM;
            ST_CAP:  if (fv_fall) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // The capture window also opens on the ARM->CAP edge itself, so a line that starts
    // together with frame valid still loses no pixel.
    always_comb begin
        busy       = (state_reg != ST_IDLE);
        done       = (state_reg == ST_CAP) && fv_fall;
        start      = (state_reg == ST_IDLE) && cmd_trig;
        cap_window = (state_reg == ST_CAP) ||
                     ((state_reg == ST_ARM) && fv_rise && (skip_reg == 4'd0));
        line_end   = (state_reg == ST_CAP) && lv_fall;
    end

    assign pix_in     = cap_window && fv_reg && lv_reg;
    assign pix_drop   = pix_in && px_valid_reg && !px.px_ready;
    assign pix_take   = pix_in && !pix_drop;
    assign line_total = line_end ? sat_inc(line_reg) : line_reg;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            skip_reg     <= '0;
            rst_cnt_reg  <= '0;
            col_reg      <= '0;
            line_reg     <= '0;
            err_ovf_reg  <= 1'b0;
            err_size_reg <= 1'b0;
        end else if (start) begin
            skip_reg     <= cmd_skip;
            rst_cnt_reg  <= '0;
            col_reg      <= '0;
            line_reg     <= '0;
            err_ovf_reg  <= 1'b0;
            err_size_reg <= 1'b0;
        end else begin
            if ((state_reg == ST_ARM) && fv_rise && (skip_reg != 4'd0)) begin
                skip_reg <= skip_reg - 4'd1;
            end
            if (state_reg == ST_SRST) begin
                rst_cnt_reg <= rst_cnt_reg + CntW'(1);
            end
            if (line_end) begin
                col_reg  <= '0;
                line_reg <= sat_inc(line_reg);
            end else if (pix_in) begin
                col_reg <= sat_inc(col_reg);
            end
            if (pix_drop) begin
                err_ovf_reg <= 1'b1;
            end
            if ((line_end && (col_reg != ImgW)) || (done && (line_total != ImgH))) begin
                err_size_reg <= 1'b1;
            end
        end
    end

    // Sensor reset follows the next state so its low phase lines up exactly with SRST.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            img_rst_reg <= 1'b0;
        end else begin
            img_rst_reg <= (state_next != ST_SRST);
        end
    end

    // A held pixel is only released by the consumer; a newcomer meeting a stall is dropped.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            px_valid_reg <= 1'b0;
            px_data_reg  <= '0;
        end else if (pix_take) begin
            px_valid_reg <= 1'b1;
            px_data_reg  <= d_reg;
        end else if (px.px_ready) begin
            px_valid_reg <= 1'b0;
        end
    end

    img_px_stats #(
        .HighlightThresh (HighlightThresh),
        .ShadowThresh    (ShadowThresh)
    ) u_stats (
        .clk     (clk),
        .rst_    (rst_),
        .clr     (start),
        .en      (pix_take),
        .pix     (d_reg),
        .stat_px (stat_px),
        .stat_hi (stat_hi),
        .stat_lo (stat_lo)
    );

    assign img_rst_    = img_rst_reg;
    assign px.px_valid = px_valid_reg;
    assign px.px_data  = px_data_reg;
    assign err_ovf     = err_ovf_reg;
    assign err_size    = err_size_reg;

endmodule
